ahb_master_burst_ctrl: RTL and testbench



---
 rtl/ahb_master_burst_ctrl_pkg.sv | 46 ++++
 rtl/ahb_master_burst_ctrl_addr_gen.sv | 55 +++++
 rtl/ahb_master_burst_ctrl.sv | 175 +++++++++++++++++
 tb/tb_ahb_master_burst_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_master_burst_ctrl_pkg.sv
// Shared AHB types, FSM state encoding and burst helpers for the master burst controller.
package ahb_master_burst_ctrl_pkg;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_type;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } htrans_type;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_BURST,
    ST_LAST_DATA
  } mst_state_t;

  localparam int unsigned ADDR_STEP = 4;

  // Beat count N; INCR length comes from the command, all others are fixed.
  function automatic logic [4:0] burst_beats(input hburst_type burst, input logic [3:0] len);
    case (burst)
      HB_SINGLE:          return 5'd1;
      HB_INCR:            return {1'b0, len} + 5'd1;
      HB_WRAP4, HB_INCR4: return 5'd4;
      HB_WRAP8, HB_INCR8: return 5'd8;
      default:            return 5'd16;
    endcase
  endfunction

  function automatic logic is_wrap(input hburst_type burst);
    return burst inside {HB_WRAP4, HB_WRAP8, HB_WRAP16};
  endfunction

endpackage

// File: rtl/ahb_master_burst_ctrl_addr_gen.sv
// Burst address generator: current address, beat counter, wrap/incr stepping, first/last flags.
module ahb_burst_addr_gen
  import ahb_master_burst_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              load,
  input  logic [ADDR_W-1:0] start_addr,
  input  hburst_type        burst,
  input  logic [3:0]        len,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              first,
  output logic              last
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] addr_next;
  logic [4:0]        beats_q;
  logic [3:0]        cnt_q;
  logic              wrap_q;

  // Wrapping keeps the bits above the 4*N window and lets only the low bits roll over.
  always_comb begin
    addr_inc  = addr_q + ADDR_W'(ADDR_STEP);
    wrap_mask = ADDR_W'({beats_q, 2'b00}) - ADDR_W'(1);
    addr_next = wrap_q ? ((addr_q & ~wrap_mask) | (addr_inc & wrap_mask)) : addr_inc;
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      beats_q <= 5'd1;
      wrap_q  <= 1'b0;
    end else if (load) begin
      addr_q  <= start_addr;
      cnt_q   <= '0;
      beats_q <= burst_beats(burst, len);
      wrap_q  <= is_wrap(burst);
    end else if (step) begin
      addr_q <= addr_next;
      cnt_q  <= cnt_q + 4'd1;
    end
  end

  assign addr  = addr_q;
  assign first = (cnt_q == '0);
  assign last  = (({1'b0, cnt_q} + 5'd1) == beats_q);

endmodule

// File: rtl/ahb_master_burst_ctrl.sv
// AHB master burst controller: requests a slave arbiter, then issues a full burst on grant.
// Optional grant-wait timeout with cmd_err output is built in with AHB_MASTER_GRANT_TIMEOUT_EN.
module ahb_master_burst_ctrl
  import ahb_master_burst_ctrl_pkg::*;
#(
  parameter int unsigned SLAVE_NUM   = 3,
  parameter int unsigned SLAVE_IDX_W = $clog2(SLAVE_NUM),
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [SLAVE_IDX_W-1:0] cmd_slave,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  hburst_type             cmd_burst,
  input  logic                   cmd_write,
  input  logic [3:0]             cmd_len,
  output logic [SLAVE_NUM-1:0]   hreq,
  input  logic [SLAVE_NUM-1:0]   hgrant,
  input  logic                   hwait,
  output logic [ADDR_W-1:0]      haddr,
  output logic [1:0]             htrans,
  output hburst_type             hburst,
  output logic                   hwrite,
  output logic [DATA_W-1:0]      hwdata,
  input  logic [DATA_W-1:0]      hrdata,
  input  logic [DATA_W-1:0]      wdata_in,
  output logic                   wdata_pop,
  output logic [DATA_W-1:0]      rdata_out,
  output logic                   rdata_valid,
  output logic                   cmd_done
`ifdef AHB_MASTER_GRANT_TIMEOUT_EN
  ,
  output logic                   cmd_err
`endif
);

  mst_state_t           state_q, state_d;
  logic [SLAVE_NUM-1:0] hreq_q, hreq_d;
  logic [SLAVE_NUM-1:0] slave_onehot;
  hburst_type           burst_q;
  logic                 write_q;
  logic [DATA_W-1:0]    hwdata_q;
  logic                 dphase_q;
  logic                 accept;
  logic                 issue;
  logic                 data_done;
  logic                 beat_first;
  logic                 beat_last;
  logic                 timeout;
  htrans_type           htrans_c;
  logic                 cmd_done_c;

  ahb_burst_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .hclk       (hclk),
    .hreset     (hreset),
    .load       (accept),
    .start_addr (cmd_addr),
    .burst      (cmd_burst),
    .len        (cmd_len),
    .step       (issue),
    .addr       (haddr),
    .first      (beat_first),
    .last       (beat_last)
  );

  // An out-of-range slave index decodes to no request bit at all.
  always_comb begin
    slave_onehot = '0;
    for (int unsigned i = 0; i < SLAVE_NUM; i++) begin
      if (cmd_slave == SLAVE_IDX_W'(i)) slave_onehot[i] = 1'b1;
    end
  end

  // hreq_q is one-hot on the selected slave throughout REQ/BURST, so masking avoids an index.
  assign issue     = ((state_q == ST_REQ) || (state_q == ST_BURST)) && |(hgrant & hreq_q);
  assign data_done = dphase_q && !hwait;

`ifdef AHB_MASTER_GRANT_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0] wait_q;

  assign timeout = (state_q == ST_REQ) && !issue && (wait_q == WAIT_W'(TIMEOUT_CYC - 1));
  assign cmd_err = timeout;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) wait_q <= '0;
    else if ((state_q == ST_REQ) && !issue && !timeout) wait_q <= wait_q + WAIT_W'(1);
    else wait_q <= '0;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    hreq_d     = hreq_q;
    accept     = 1'b0;
    htrans_c   = HT_IDLE;
    cmd_done_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          hreq_d  = slave_onehot;
          state_d = ST_REQ;
        end
      end
      ST_REQ, ST_BURST: begin
        if (issue) begin
          htrans_c = beat_first ? HT_NONSEQ : HT_SEQ;
          state_d  = ST_BURST;
          if (beat_last) begin
            hreq_d  = '0;
            state_d = ST_LAST_DATA;
          end
        end else if (timeout) begin
          hreq_d  = '0;
          state_d = ST_IDLE;
        end
      end
      ST_LAST_DATA: begin
        if (data_done) begin
          cmd_done_c = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= ST_IDLE;
      hreq_q  <= '0;
    end else begin
      state_q <= state_d;
      hreq_q  <= hreq_d;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      burst_q  <= HB_SINGLE;
      write_q  <= 1'b0;
      hwdata_q <= '0;
      dphase_q <= 1'b0;
    end else begin
      if (accept) begin
        burst_q <= cmd_burst;
        write_q <= cmd_write;
      end
      if (issue && write_q) hwdata_q <= wdata_in;
      // An issue implies hwait=0, so any earlier data phase completes in the same cycle.
      dphase_q <= issue | (dphase_q & hwait);
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign hreq        = hreq_q;
  assign htrans      = htrans_c;
  assign hburst      = burst_q;
  assign hwrite      = write_q;
  assign hwdata      = hwdata_q;
  assign wdata_pop   = issue && write_q;
  assign rdata_out   = hrdata;
  assign rdata_valid = data_done && !write_q;
  assign cmd_done    = cmd_done_c;

endmodule

// File: tb/tb_ahb_master_burst_ctrl.sv
// Scoreboard bench for ahb_master_burst_ctrl: expected beats/data are queued per command and
// consumed as the DUT drives address beats, write data and read completions.
module tb_ahb_master_burst_ctrl;
  import ahb_master_burst_ctrl_pkg::*;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_slave;
  logic [31:0] cmd_addr;
  hburst_type  cmd_burst;
  logic        cmd_write;
  logic [3:0]  cmd_len;
  logic [2:0]  hreq;
  logic [2:0]  hgrant;
  logic        hwait;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  hburst_type  hburst;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic [31:0] wdata_in;
  logic        wdata_pop;
  logic [31:0] rdata_out;
  logic        rdata_valid;
  logic        cmd_done;
`ifdef AHB_MASTER_GRANT_TIMEOUT_EN
  logic        cmd_err;
`endif
  logic        grant_en;

  int n_checks = 0;
  int n_fail   = 0;
  int pop_cnt  = 0;

  logic [37:0] exp_addr[$];
  logic [31:0] exp_wdata[$];
  logic [31:0] exp_rdata[$];
  logic [31:0] wd_src[$];
  logic [31:0] rd_src[$];
  bit          prev_wr = 1'b0;
  bit          wd_pend = 1'b0;

  always #5 hclk = ~hclk;

  // Arbiter model: grants the requested slave unless stalled or deliberately withheld.
  assign hgrant = (grant_en && !hwait) ? hreq : 3'b000;

  ahb_master_burst_ctrl #(
    .SLAVE_NUM   (3),
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (8)
  ) dut (
    .hclk        (hclk),
    .hreset      (hreset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_slave   (cmd_slave),
    .cmd_addr    (cmd_addr),
    .cmd_burst   (cmd_burst),
    .cmd_write   (cmd_write),
    .cmd_len     (cmd_len),
    .hreq        (hreq),
    .hgrant      (hgrant),
    .hwait       (hwait),
    .haddr       (haddr),
    .htrans      (htrans),
    .hburst      (hburst),
    .hwrite      (hwrite),
    .hwdata      (hwdata),
    .hrdata      (hrdata),
    .wdata_in    (wdata_in),
    .wdata_pop   (wdata_pop),
    .rdata_out   (rdata_out),
    .rdata_valid (rdata_valid),
    .cmd_done    (cmd_done)
`ifdef AHB_MASTER_GRANT_TIMEOUT_EN
    ,
    .cmd_err     (cmd_err)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
    check_eq({tag, "_hreq"}, 64'(hreq), 64'(0));
    check_eq({tag, "_htrans"}, 64'(htrans), 64'(0));
    check_eq({tag, "_haddr"}, 64'(haddr), 64'(0));
    check_eq({tag, "_hburst"}, 64'(hburst), 64'(HB_SINGLE));
    check_eq({tag, "_hwrite"}, 64'(hwrite), 64'(0));
    check_eq({tag, "_hwdata"}, 64'(hwdata), 64'(0));
    check_eq({tag, "_wdata_pop"}, 64'(wdata_pop), 64'(0));
    check_eq({tag, "_rdata_valid"}, 64'(rdata_valid), 64'(0));
    check_eq({tag, "_cmd_done"}, 64'(cmd_done), 64'(0));
  endtask

  // Monitor: consumes expected beats, write data and read data as the DUT produces them.
  always @(negedge hclk) begin
    if (hreset) begin
      prev_wr = 1'b0;
      wd_pend = 1'b0;
    end else begin
      if (wd_pend) begin
        if (wd_src.size() != 0) void'(wd_src.pop_front());
        wdata_in = (wd_src.size() != 0) ? wd_src[0] : 32'h0;
      end
      wd_pend = wdata_pop;
      if (wdata_pop) pop_cnt++;
      if (prev_wr) begin
        check_eq("hwdata_queued", 64'(exp_wdata.size() != 0), 64'(1));
        if (exp_wdata.size() != 0) check_eq("hwdata", 64'(hwdata), 64'(exp_wdata.pop_front()));
      end
      prev_wr = (htrans != 2'd0) && hwrite;
      if (htrans != 2'd0) begin
        check_eq("beat_queued", 64'(exp_addr.size() != 0), 64'(1));
        if (exp_addr.size() != 0)
          check_eq("addr_beat", 64'({htrans, hburst, hwrite, haddr}), 64'(exp_addr.pop_front()));
      end
      if (rdata_valid) begin
        check_eq("rdata_queued", 64'(exp_rdata.size() != 0), 64'(1));
        if (exp_rdata.size() != 0) check_eq("rdata", 64'(rdata_out), 64'(exp_rdata.pop_front()));
        if (rd_src.size() != 0) void'(rd_src.pop_front());
        hrdata = (rd_src.size() != 0) ? rd_src[0] : 32'h0;
      end
    end
  end

  task automatic push_beats(input int tid, input logic [31:0] addr, input hburst_type b,
                            input logic wr, input logic [3:0] len, output int n);
    logic [31:0] win, base, a, d;
    case (b)
      HB_SINGLE:          n = 1;
      HB_INCR:            n = int'(len) + 1;
      HB_WRAP4, HB_INCR4: n = 4;
      HB_WRAP8, HB_INCR8: n = 8;
      default:            n = 16;
    endcase
    win  = 32'(4 * n);
    base = addr & ~(win - 32'd1);
    for (int k = 0; k < n; k++) begin
      if (b inside {HB_WRAP4, HB_WRAP8, HB_WRAP16}) a = base + ((addr - base + 32'(4 * k)) % win);
      else a = addr + 32'(4 * k);
      exp_addr.push_back({(k == 0) ? 2'd2 : 2'd3, b, wr, a});
      d = {wr ? 8'hA5 : 8'h5A, 8'(tid), 16'(k)};
      if (wr) begin
        wd_src.push_back(d);
        exp_wdata.push_back(d);
      end else begin
        rd_src.push_back(d);
        exp_rdata.push_back(d);
      end
    end
    if (wd_src.size() != 0) wdata_in = wd_src[0];
    if (rd_src.size() != 0) hrdata = rd_src[0];
  endtask

  // Cycle 1 is the first REQ cycle; grant opens after gdly cycles, hwait/gap windows add stalls.
  task automatic run_cmd(input int tid, input logic [1:0] slv, input logic [31:0] addr,
                         input hburst_type b, input logic wr, input logic [3:0] len,
                         input int gdly, input int st_at, input int st_len,
                         input int gp_at, input int gp_len, input bit inject);
    int n, cyc, exp_done;
    bit done;
    push_beats(tid, addr, b, wr, len, n);
    pop_cnt  = 0;
    exp_done = n + 1 + gdly + st_len + gp_len;
    @(posedge hclk); #1;
    check_eq("ready_before_cmd", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_slave = slv; cmd_addr = addr;
    cmd_burst = b; cmd_write = wr; cmd_len = len; grant_en = 1'b0;
    cyc = 0; done = 1'b0;
    while (!done && cyc < exp_done + 20) begin
      @(posedge hclk); #1;
      cyc++;
      cmd_valid = inject && (cyc == exp_done);
      cmd_slave = 2'd0; cmd_addr = 32'hFFF0; cmd_burst = HB_INCR16;
      grant_en  = (cyc > gdly) && !(cyc >= gp_at && cyc < gp_at + gp_len);
      hwait     = (cyc >= st_at) && (cyc < st_at + st_len);
      @(negedge hclk);
      if (cyc == 1) check_eq("hreq_onehot", 64'(hreq), 64'(3'b001 << slv));
      if (cmd_done) begin
        done = 1'b1;
        check_eq("done_cycle", 64'(cyc), 64'(exp_done));
        check_eq("ready_at_done", 64'(cmd_ready), 64'(0));
      end
    end
    check_eq("cmd_done_seen", 64'(done), 64'(1));
    @(posedge hclk); #1;
    cmd_valid = 1'b0; hwait = 1'b0;
    check_eq("ready_after_done", 64'(cmd_ready), 64'(1));
    check_eq("hreq_after_done", 64'(hreq), 64'(0));
    check_eq("done_pulse_1cyc", 64'(cmd_done), 64'(0));
    check_eq("beats_left", 64'(exp_addr.size()), 64'(0));
    check_eq("wdata_left", 64'(exp_wdata.size()), 64'(0));
    check_eq("rdata_left", 64'(exp_rdata.size()), 64'(0));
    check_eq("wdata_pops", 64'(pop_cnt), 64'(wr ? n : 0));
    grant_en = 1'b1;
    repeat (3) @(posedge hclk);
    #1;
    check_eq("still_idle", 64'(cmd_ready), 64'(1));
    grant_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    hreset = 1'b1; cmd_valid = 1'b0; cmd_slave = 2'd0; cmd_addr = '0;
    cmd_burst = HB_SINGLE; cmd_write = 1'b0; cmd_len = '0; hwait = 1'b0;
    grant_en = 1'b0; hrdata = '0; wdata_in = '0;
    repeat (2) @(posedge hclk);
    #1;
    check_reset_vals("rst");
    hreset = 1'b0;

    run_cmd(1, 2'd1, 32'h100, HB_SINGLE, 1'b1, 4'd0, 2, 0, 0, 0, 0, 1'b1);
    run_cmd(2, 2'd0, 32'h020, HB_INCR4,  1'b0, 4'd0, 0, 0, 0, 0, 0, 1'b0);
    run_cmd(3, 2'd2, 32'h038, HB_WRAP4,  1'b0, 4'd0, 0, 0, 0, 0, 0, 1'b0);
    run_cmd(4, 2'd1, 32'h200, HB_INCR8,  1'b1, 4'd0, 0, 3, 3, 0, 0, 1'b0);
    run_cmd(5, 2'd0, 32'h074, HB_WRAP8,  1'b0, 4'd0, 0, 0, 0, 4, 2, 1'b0);
    run_cmd(6, 2'd2, 32'h3F0, HB_INCR,   1'b1, 4'd5, 0, 0, 0, 0, 0, 1'b0);
    run_cmd(7, 2'd1, 32'h00C, HB_WRAP16, 1'b1, 4'd0, 1, 5, 2, 9, 1, 1'b0);

`ifdef AHB_MASTER_GRANT_TIMEOUT_EN
    begin
      int err_cyc;
      err_cyc = 0;
      @(posedge hclk); #1;
      cmd_valid = 1'b1; cmd_slave = 2'd0; cmd_addr = 32'h40; cmd_burst = HB_INCR4; cmd_write = 1'b1;
      grant_en = 1'b0;
      for (int c = 1; c <= 20 && err_cyc == 0; c++) begin
        @(posedge hclk); #1;
        cmd_valid = 1'b0;
        @(negedge hclk);
        if (cmd_err) err_cyc = c;
      end
      check_eq("timeout_cycle", 64'(err_cyc), 64'(8));
      @(posedge hclk); #1;
      check_eq("timeout_hreq", 64'(hreq), 64'(0));
      check_eq("timeout_ready", 64'(cmd_ready), 64'(1));
    end
`endif

    // Out-of-range slave: accepted, no request bit, no beats.
    @(posedge hclk); #1;
    cmd_valid = 1'b1; cmd_slave = 2'd3; cmd_addr = 32'h80; cmd_burst = HB_INCR4; cmd_write = 1'b0;
    grant_en = 1'b1;
    repeat (4) begin
      @(posedge hclk); #1;
      cmd_valid = 1'b0;
    end
    check_eq("badslv_hreq", 64'(hreq), 64'(0));
    check_eq("badslv_ready", 64'(cmd_ready), 64'(0));
    check_eq("badslv_htrans", 64'(htrans), 64'(0));
    hreset = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0;

    // Reset in the middle of an INCR16 read, during beat 5.
    push_beats(9, 32'h800, HB_INCR16, 1'b0, 4'd0, n);
    @(posedge hclk); #1;
    cmd_valid = 1'b1; cmd_slave = 2'd0; cmd_addr = 32'h800; cmd_burst = HB_INCR16; cmd_write = 1'b0;
    grant_en = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge hclk); #1;
      cmd_valid = 1'b0;
    end
    hreset = 1'b1;
    #1;
    check_reset_vals("midrst");
    check_eq("beats_before_reset", 64'(exp_addr.size()), 64'(n - 4));
    exp_addr.delete(); exp_rdata.delete(); rd_src.delete();
    hrdata = '0; grant_en = 1'b0;
    repeat (2) @(posedge hclk);
    #1;
    hreset = 1'b0;
    run_cmd(10, 2'd2, 32'h1F8, HB_WRAP4, 1'b1, 4'd0, 0, 0, 0, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
